// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Decode-stage operand forwarding with an internal in-flight destination
//   tag pipe, load-use stall detection and a busy scoreboard for
//   out-of-band long-latency ops (divider and similar).
//
//   Optional feature macro: LONG_FWD_EN
//     defined   : a busy source whose long op completes this cycle is
//                 bypassed from wb_long_val_i (below any pipe-tag match)
//     undefined : a busy source always stalls; the operand is read from
//                 the register file the cycle after completion
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   hold_i             global freeze of the tag pipe
//   flush_i            squash stage-0 tag and the current issue
//   issue_*            instruction presented by decode
//   rs_i, rval_i       per-port source register and register-file data
//   stage_val_i        result value per downstream stage (0 = E)
//   stage_rdy_i        value in stage k is final
//   wb_long_*          long-op completion
//   fwd_val_o          forwarded operand per port
//   stall_o            decode must not advance
//   long_cnt_o         outstanding long ops
module fwd_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NRD      = 2,
  parameter int STAGES   = 3,
  parameter int MAX_LONG = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          hold_i,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  input  logic                          issue_wen_i,
  input  logic                          issue_long_i,
  input  logic [4:0]                    issue_rd_i,
  input  logic [NRD*5-1:0]              rs_i,
  input  logic [NRD*XLEN-1:0]           rval_i,
  input  logic [STAGES*XLEN-1:0]        stage_val_i,
  input  logic [STAGES-1:0]             stage_rdy_i,
  input  logic                          wb_long_valid_i,
  input  logic [4:0]                    wb_long_rd_i,
  input  logic [XLEN-1:0]               wb_long_val_i,
  output logic [NRD*XLEN-1:0]           fwd_val_o,
  output logic                          stall_o,
  output logic [$clog2(MAX_LONG+1)-1:0] long_cnt_o
);

  localparam int CW = $clog2(MAX_LONG+1);

  // Tag pipe state
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_wen;
  logic [4:0]        r_rd [STAGES];

  // Scoreboard state
  logic [31:0]       r_busy;
  logic [CW-1:0]     r_cnt;

  logic [NRD-1:0]    w_pstall;
  logic [4:0]        w_rs;
  logic              w_found;
  logic [XLEN-1:0]   w_val;
  logic              w_st;
  logic              w_waw;
  logic              w_full;
  logic              w_acc;
  logic              w_inc;
  logic              w_dec;
  logic [31:0]       w_busy_nxt;

  // Per-port forwarding. Stages are scanned from youngest (0) to oldest;
  // the first hit wins so a younger writer shadows an older one.
  always_comb begin
    fwd_val_o = '0;
    w_pstall  = '0;
    w_rs      = '0;
    w_found   = 1'b0;
    w_val     = '0;
    w_st      = 1'b0;
    for (int unsigned p = 0; p < NRD; p++) begin
      w_rs    = rs_i[5*p +: 5];
      w_found = 1'b0;
      w_st    = 1'b0;
      w_val   = rval_i[p*XLEN +: XLEN];
      if (w_rs == 5'd0) begin
        w_val = '0;
      end else begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          if (!w_found && r_vld[k] && r_wen[k] && (r_rd[k] == w_rs)) begin
            w_found = 1'b1;
            if (stage_rdy_i[k]) w_val = stage_val_i[k*XLEN +: XLEN];
            else                w_st  = 1'b1;
          end
        end
        if (!w_found && r_busy[w_rs]) begin
`ifdef LONG_FWD_EN
          if (wb_long_valid_i && (wb_long_rd_i == w_rs)) w_val = wb_long_val_i;
          else                                           w_st  = 1'b1;
`else
          w_st = 1'b1;
`endif
        end
      end
      fwd_val_o[p*XLEN +: XLEN] = w_val;
      w_pstall[p]               = w_st;
    end
  end

  assign w_waw   = (issue_wen_i | issue_long_i) & r_busy[issue_rd_i] & (issue_rd_i != 5'd0);
  assign w_full  = issue_long_i & (r_cnt == CW'(MAX_LONG));
  assign stall_o = issue_valid_i & ((|w_pstall) | w_waw | w_full);
  assign w_acc   = issue_valid_i & ~stall_o & ~flush_i & ~hold_i;

  // Tag pipe. Under hold the pipe freezes, but a flush still kills stage 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      r_wen <= '0;
      for (int unsigned k = 0; k < STAGES; k++) r_rd[k] <= '0;
    end else if (hold_i) begin
      if (flush_i) r_vld[0] <= 1'b0;
    end else begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_wen[k] <= r_wen[k-1];
        r_rd[k]  <= r_rd[k-1];
      end
      r_vld[0] <= w_acc;
      r_wen[0] <= w_acc & issue_wen_i & ~issue_long_i;
      r_rd[0]  <= w_acc ? issue_rd_i : 5'd0;
    end
  end

  assign w_inc = w_acc & issue_long_i;
  assign w_dec = wb_long_valid_i & (r_cnt != '0);

  // Clear applied before set so a same-register set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_long_valid_i) w_busy_nxt[wb_long_rd_i] = 1'b0;
    if (w_inc && (issue_rd_i != 5'd0)) w_busy_nxt[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_inc && !w_dec)      r_cnt <= r_cnt + CW'(1);
      else if (!w_inc && w_dec) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign long_cnt_o = r_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold, flush, iv, iw, il;
  logic [4:0]  ird, rs0, rs1, wbrd;
  logic [31:0] rv0, rv1, wbval;
  logic [31:0] sv [3];
  logic [2:0]  rdy;
  logic        wbv;

  logic [63:0] fwd;
  logic        stall;
  logic [2:0]  cnt;

  always #5 clk = ~clk;

  fwd_scoreboard #(.XLEN(32), .NRD(2), .STAGES(3), .MAX_LONG(4)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .issue_valid_i(iv), .issue_wen_i(iw), .issue_long_i(il), .issue_rd_i(ird),
    .rs_i({rs1, rs0}), .rval_i({rv1, rv0}),
    .stage_val_i({sv[2], sv[1], sv[0]}), .stage_rdy_i(rdy),
    .wb_long_valid_i(wbv), .wb_long_rd_i(wbrd), .wb_long_val_i(wbval),
    .fwd_val_o(fwd), .stall_o(stall), .long_cnt_o(cnt)
  );

  typedef struct {
    string       nm;
    bit          cf0;
    logic [31:0] f0;
    bit          cf1;
    logic [31:0] f1;
    logic        st;
    logic [2:0]  cn;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: the DUT is purely combinational from the registered state, so
  // every expectation pushed during a cycle is checked at that cycle's
  // falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.cf0) cmp({e.nm, ".fwd0"}, fwd[31:0], e.f0);
        if (e.cf1) cmp({e.nm, ".fwd1"}, fwd[63:32], e.f1);
        cmp({e.nm, ".stall"}, {31'd0, stall}, {31'd0, e.st});
        cmp({e.nm, ".cnt"}, {29'd0, cnt}, {29'd0, e.cn});
      end
    end
  end

  task automatic ex(string nm, bit cf0, logic [31:0] f0, bit cf1, logic [31:0] f1,
                    logic st, logic [2:0] cn);
    exp_t e;
    e.nm = nm; e.cf0 = cf0; e.f0 = f0; e.cf1 = cf1; e.f1 = f1; e.st = st; e.cn = cn;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    hold = 0; flush = 0; iv = 0; iw = 0; il = 0; ird = 0;
    rs0 = 0; rs1 = 0; rv0 = 32'h0A0A; rv1 = 32'h0B0B;
    sv[0] = 32'hBAD0; sv[1] = 32'hBAD1; sv[2] = 32'hBAD2; rdy = 3'b111;
    wbv = 0; wbrd = 0; wbval = 0;
  endtask

  task automatic iss(logic w, logic l, logic [4:0] rd);
    iv = 1; iw = w; il = l; ird = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hold = 0; flush = 0; iv = 0; iw = 0; il = 0; ird = 0; rs0 = 0; rs1 = 0;
    rv0 = 0; rv1 = 0; sv[0] = 0; sv[1] = 0; sv[2] = 0; rdy = 0;
    wbv = 0; wbrd = 0; wbval = 0;

    // Reset state
    step(); iss(1, 0, 5); rs0 = 5; ex("rst", 1, 32'h0A0A, 0, 0, 0, 0);

    // Tag pipe: rd=5 walks through E, M, W then retires
    step(); rst = 0; iss(1, 0, 5); rv0 = 32'h77; ex("x0_rs", 1, 0, 0, 0, 0, 0);
    step(); iss(0, 0, 0); rs0 = 5; sv[0] = 32'h1234; ex("fwd_s0", 1, 32'h1234, 0, 0, 0, 0);
    step(); rs0 = 5; sv[1] = 32'h1234; ex("fwd_s1", 1, 32'h1234, 0, 0, 0, 0);
    step(); rs0 = 5; sv[2] = 32'h1234; ex("fwd_s2", 1, 32'h1234, 0, 0, 0, 0);
    step(); rs0 = 5; rv0 = 32'h5555; ex("retired", 1, 32'h5555, 0, 0, 0, 0);

    // Load-use
    step(); iss(1, 0, 7);
    step(); iss(1, 0, 8); rs0 = 7; rdy = 3'b110; rv0 = 32'h1111;
    ex("lu_stall", 1, 32'h1111, 0, 0, 1, 0);
    step(); iss(1, 0, 8); rs0 = 7; sv[1] = 32'hDEAD; ex("lu_fwd", 1, 32'hDEAD, 0, 0, 0, 0);

    // Priority: rd=3 in stage 0 and stage 2, rd=4 in stage 1
    step(); iss(1, 0, 3);
    step(); iss(1, 0, 4);
    step(); iss(1, 0, 3);
    step(); iss(1, 0, 0); rs0 = 3; rs1 = 4;
    sv[0] = 32'hA; sv[1] = 32'hC; sv[2] = 32'hB;
    ex("prio", 1, 32'hA, 1, 32'hC, 0, 0);
    step(); iss(1, 0, 0); rdy = 3'b000; sv[0] = 32'h99;
    ex("x0_tag", 1, 0, 1, 0, 0, 0);
    step(); step(); step();

    // Scoreboard fill
    step(); iss(1, 1, 1); ex("long1", 0, 0, 0, 0, 0, 0);
    step(); iss(1, 1, 2); ex("long2", 0, 0, 0, 0, 0, 1);
    step(); iss(1, 1, 3); ex("long3", 0, 0, 0, 0, 0, 2);
    step(); iss(1, 1, 4); ex("long4", 0, 0, 0, 0, 0, 3);
    step(); iss(1, 1, 5); ex("long_full", 0, 0, 0, 0, 1, 4);
    step(); iss(1, 0, 6); rs0 = 2; ex("busy", 0, 0, 0, 0, 1, 4);
    step(); iss(1, 0, 6); rs0 = 2; rv0 = 32'h22; wbv = 1; wbrd = 2; wbval = 32'h55;
`ifdef LONG_FWD_EN
    ex("wb_byp", 1, 32'h55, 0, 0, 0, 4);
`else
    ex("wb_stall", 0, 0, 0, 0, 1, 4);
`endif
    step(); iss(1, 0, 6); rs0 = 2; rv0 = 32'h22; ex("after_wb", 1, 32'h22, 0, 0, 0, 3);

    // Simultaneous set/clear of rd=9
    step(); iss(1, 1, 9); wbv = 1; wbrd = 9; ex("set_clr", 0, 0, 0, 0, 0, 3);
    step(); iss(1, 0, 10); rs0 = 9; ex("busy9", 0, 0, 0, 0, 1, 3);
    step(); iss(1, 0, 9); ex("waw", 0, 0, 0, 0, 1, 3);
    step(); wbv = 1; wbrd = 1; ex("drain1", 0, 0, 0, 0, 0, 3);
    step(); wbv = 1; wbrd = 3; ex("drain3", 0, 0, 0, 0, 0, 2);
    step(); wbv = 1; wbrd = 4; ex("drain4", 0, 0, 0, 0, 0, 1);
    step(); wbv = 1; wbrd = 9; ex("drain9", 0, 0, 0, 0, 0, 0);
    step(); ex("cnt_floor", 0, 0, 0, 0, 0, 0);

    // Hold freezes tags
    step(); iss(1, 0, 12);
    step(); hold = 1; iss(1, 0, 13); rs0 = 12; sv[0] = 32'h1200;
    ex("hold0", 1, 32'h1200, 0, 0, 0, 0);
    step(); hold = 1; iss(1, 0, 13); rs0 = 12; sv[0] = 32'h1200;
    ex("hold1", 1, 32'h1200, 0, 0, 0, 0);
    step(); rs0 = 12; sv[0] = 32'h1200; ex("hold_rel", 1, 32'h1200, 0, 0, 0, 0);
    step(); rs0 = 12; sv[1] = 32'h1201; ex("hold_adv", 1, 32'h1201, 0, 0, 0, 0);

    // Flush blocks tag and busy insertion
    step(); flush = 1; iss(1, 0, 14); ex("flush_alu", 0, 0, 0, 0, 0, 0);
    step(); flush = 1; iss(1, 1, 16); ex("flush_long", 0, 0, 0, 0, 0, 0);
    step(); iss(1, 0, 17); rs0 = 14; rv0 = 32'h1414; rs1 = 16; rv1 = 32'h1616;
    ex("flushed", 1, 32'h1414, 1, 32'h1616, 0, 0);

    // Flush beats hold on stage 0
    step(); iss(1, 0, 20);
    step(); hold = 1; flush = 1;
    step(); rs0 = 20; rv0 = 32'h2020; ex("flush_hold", 1, 32'h2020, 0, 0, 0, 0);

    // Asynchronous reset mid-stream
    step(); iss(1, 1, 21); ex("pre_rst_l", 0, 0, 0, 0, 0, 0);
    step(); iss(1, 0, 22); rs0 = 21; ex("pre_rst", 0, 0, 0, 0, 1, 1);
    step(); rst = 1; iss(1, 0, 22); rs0 = 21; rv0 = 32'h2121;
    ex("async_rst", 1, 32'h2121, 0, 0, 0, 0);
    step(); rst = 0; iss(1, 0, 22); rs0 = 21; rv0 = 32'h2121;
    ex("post_rst", 1, 32'h2121, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
